multicycle_control: RTL and testbench

//  Multicycle control FSM that drives the datapath control inputs (en, PC_sel, RFsel_wr,

---
 rtl/multicycle_control.sv | 258 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multicycle processor control FSM. Walks each instruction
//                through FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and drives
//                the datapath control lines. The PC enable (en) pulses once
//                per instruction, in its last cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    OP_W     opcode width, taken from instr[31:32-OP_W]
//    FUNC_W   ALU function code width
//  Ports
//    clk       in   clock, rising edge
//    reset     in   synchronous active-high reset
//    instr     in   current instruction (stable while PC is not enabled)
//    zero      in   ALU zero flag, consulted only in EXEC of beq/bne
//    en        out  PC write enable, one-cycle pulse at instruction end
//    PC_sel    out  0: PC+4, 1: PC+4+(immed<<2)
//    RFsel_wr  out  RF write data select, 0: ALU_out, 1: MEM_out
//    RFsel_B   out  RF port B address, 0: instr[15:11], 1: instr[20:16]
//    RFwr_en   out  register file write enable
//    ALUsel_B  out  ALU operand B, 0: RF_B, 1: immediate
//    MEMwr_en  out  data memory write enable
//    func      out  ALU function code
//    illegal   out  sticky undefined-opcode flag
//  Configuration macro
//    ILLEGAL_TRAP_EN  defined  : undefined opcode traps into HALT (illegal=1),
//                                left only by reset
//                     undefined: undefined opcode executes as a NOP
// ============================================================================
module multicycle_control #(
    parameter int OP_W   = 6,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              zero,
    output logic              en,
    output logic              PC_sel,
    output logic              RFsel_wr,
    output logic              RFsel_B,
    output logic              RFwr_en,
    output logic              ALUsel_B,
    output logic              MEMwr_en,
    output logic [FUNC_W-1:0] func,
    output logic              illegal
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_S_FETCH  = 3'd0;
    localparam logic [2:0] c_S_DECODE = 3'd1;
    localparam logic [2:0] c_S_EXEC   = 3'd2;
    localparam logic [2:0] c_S_MEM    = 3'd3;
    localparam logic [2:0] c_S_WB     = 3'd4;
    localparam logic [2:0] c_S_HALT   = 3'd5;

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [OP_W-1:0] c_OP_RTYPE = 6'b100000;
    localparam logic [OP_W-1:0] c_OP_LI    = 6'b111000;
    localparam logic [OP_W-1:0] c_OP_LUI   = 6'b111001;
    localparam logic [OP_W-1:0] c_OP_ADDI  = 6'b110000;
    localparam logic [OP_W-1:0] c_OP_NANDI = 6'b110010;
    localparam logic [OP_W-1:0] c_OP_ORI   = 6'b110011;
    localparam logic [OP_W-1:0] c_OP_B     = 6'b111111;
    localparam logic [OP_W-1:0] c_OP_BEQ   = 6'b000000;
    localparam logic [OP_W-1:0] c_OP_BNE   = 6'b000001;
    localparam logic [OP_W-1:0] c_OP_LB    = 6'b000011;
    localparam logic [OP_W-1:0] c_OP_SB    = 6'b000111;
    localparam logic [OP_W-1:0] c_OP_LW    = 6'b001111;
    localparam logic [OP_W-1:0] c_OP_SW    = 6'b011111;

    // ALU function codes
    localparam logic [FUNC_W-1:0] c_FN_ADD  = 4'b0000;
    localparam logic [FUNC_W-1:0] c_FN_SUB  = 4'b0001;
    localparam logic [FUNC_W-1:0] c_FN_OR   = 4'b0011;
    localparam logic [FUNC_W-1:0] c_FN_NAND = 4'b0101;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [OP_W-1:0]   r_op;
    logic [FUNC_W-1:0] r_fn;

    // Opcode field of the incoming instruction (only looked at in DECODE)
    logic [OP_W-1:0] w_instr_op;
    assign w_instr_op = instr[31:32-OP_W];

    // Middle instruction bits belong to the datapath, not to control
    logic w_unused_instr;
    assign w_unused_instr = &{1'b0, instr[31-OP_W:FUNC_W]};

    function automatic logic f_is_known(input logic [OP_W-1:0] op);
        case (op)
            c_OP_RTYPE, c_OP_LI, c_OP_LUI, c_OP_ADDI, c_OP_NANDI, c_OP_ORI,
            c_OP_B, c_OP_BEQ, c_OP_BNE, c_OP_LB, c_OP_SB, c_OP_LW, c_OP_SW:
                f_is_known = 1'b1;
            default:
                f_is_known = 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Classification of the latched opcode
    // ------------------------------------------------------------------
    logic w_is_rtype, w_is_addlike, w_is_nandi, w_is_ori;
    logic w_is_b, w_is_beq, w_is_bne, w_is_load, w_is_store;
    logic w_is_branch, w_is_known;

    assign w_is_rtype   = (r_op == c_OP_RTYPE);
    assign w_is_addlike = (r_op == c_OP_LI) || (r_op == c_OP_LUI) || (r_op == c_OP_ADDI);
    assign w_is_nandi   = (r_op == c_OP_NANDI);
    assign w_is_ori     = (r_op == c_OP_ORI);
    assign w_is_b       = (r_op == c_OP_B);
    assign w_is_beq     = (r_op == c_OP_BEQ);
    assign w_is_bne     = (r_op == c_OP_BNE);
    assign w_is_load    = (r_op == c_OP_LB) || (r_op == c_OP_LW);
    assign w_is_store   = (r_op == c_OP_SB) || (r_op == c_OP_SW);
    assign w_is_branch  = w_is_b || w_is_beq || w_is_bne;
    assign w_is_known   = f_is_known(r_op);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_FETCH;
            r_op    <= '0;
            r_fn    <= '0;
        end else begin
            case (r_state)
                c_S_FETCH: begin
                    r_state <= c_S_DECODE;
                end
                c_S_DECODE: begin
                    r_op <= w_instr_op;
                    r_fn <= instr[FUNC_W-1:0];
`ifdef ILLEGAL_TRAP_EN
                    r_state <= f_is_known(w_instr_op) ? c_S_EXEC : c_S_HALT;
`else
                    r_state <= c_S_EXEC;
`endif
                end
                c_S_EXEC: begin
                    // Branches and (non-trapping) unknown opcodes finish here
                    if (w_is_branch || !w_is_known)
                        r_state <= c_S_FETCH;
                    else if (w_is_load || w_is_store)
                        r_state <= c_S_MEM;
                    else
                        r_state <= c_S_WB;
                end
                c_S_MEM: begin
                    r_state <= w_is_store ? c_S_FETCH : c_S_WB;
                end
                c_S_WB: begin
                    r_state <= c_S_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                c_S_HALT: begin
                    r_state <= c_S_HALT;
                end
`endif
                default: begin
                    r_state <= c_S_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Moore in (state, op, fn); PC_sel additionally looks
    // at zero. Everything is forced low while reset is high so that a reset
    // landing in MEM or WB cannot write anything.
    // ------------------------------------------------------------------
    logic w_alu_phase;
    assign w_alu_phase = (r_state == c_S_EXEC) || (r_state == c_S_MEM) || (r_state == c_S_WB);

    always_comb begin
        en       = 1'b0;
        PC_sel   = 1'b0;
        RFsel_wr = 1'b0;
        RFsel_B  = 1'b0;
        RFwr_en  = 1'b0;
        ALUsel_B = 1'b0;
        MEMwr_en = 1'b0;
        func     = c_FN_ADD;
        illegal  = 1'b0;

        // ALU controls are held from EXEC through WB
        if (w_alu_phase) begin
            if (w_is_rtype) begin
                func = r_fn;
            end else if (w_is_nandi) begin
                ALUsel_B = 1'b1;
                func     = c_FN_NAND;
            end else if (w_is_ori) begin
                ALUsel_B = 1'b1;
                func     = c_FN_OR;
            end else if (w_is_addlike || w_is_load || w_is_store) begin
                ALUsel_B = 1'b1;
                func     = c_FN_ADD;
            end else if (w_is_beq || w_is_bne) begin
                func = c_FN_SUB;
            end
            RFsel_B = w_is_beq || w_is_bne || w_is_store;
        end

        case (r_state)
            c_S_EXEC: begin
                if (w_is_branch) begin
                    en     = 1'b1;
                    PC_sel = w_is_b || (w_is_beq && zero) || (w_is_bne && !zero);
                end else if (!w_is_known) begin
                    en = 1'b1;
                end
            end
            c_S_MEM: begin
                if (w_is_store) begin
                    MEMwr_en = 1'b1;
                    en       = 1'b1;
                end
            end
            c_S_WB: begin
                RFwr_en  = 1'b1;
                en       = 1'b1;
                RFsel_wr = w_is_load;
            end
`ifdef ILLEGAL_TRAP_EN
            c_S_HALT: begin
                illegal = 1'b1;
            end
`endif
            default: begin
            end
        endcase

        if (reset) begin
            en       = 1'b0;
            PC_sel   = 1'b0;
            RFsel_wr = 1'b0;
            RFsel_B  = 1'b0;
            RFwr_en  = 1'b0;
            ALUsel_B = 1'b0;
            MEMwr_en = 1'b0;
            func     = c_FN_ADD;
            illegal  = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. A per-instruction
//                reference model gives the expected control word for every
//                cycle of an instruction, from the opcode class and the
//                latency table; random instructions, zero flags and
//                occasional mid-instruction resets are applied.
//                Honours ILLEGAL_TRAP_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        en, PC_sel, RFsel_wr, RFsel_B, RFwr_en, ALUsel_B, MEMwr_en, illegal;
    logic [3:0]  func;

    multicycle_control #(.OP_W(6), .FUNC_W(4)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .zero     (zero),
        .en       (en),
        .PC_sel   (PC_sel),
        .RFsel_wr (RFsel_wr),
        .RFsel_B  (RFsel_B),
        .RFwr_en  (RFwr_en),
        .ALUsel_B (ALUsel_B),
        .MEMwr_en (MEMwr_en),
        .func     (func),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
    localparam bit c_TRAP = 1'b1;
`else
    localparam bit c_TRAP = 1'b0;
`endif

    // Control word: {en, PC_sel, RFsel_wr, RFsel_B, RFwr_en, ALUsel_B, MEMwr_en, func, illegal}
    logic [11:0] w_dut_vec;
    assign w_dut_vec = {en, PC_sel, RFsel_wr, RFsel_B, RFwr_en, ALUsel_B, MEMwr_en, func, illegal};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %03h expected %03h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction classes
    localparam int K_R = 0, K_ADD = 1, K_NANDI = 2, K_ORI = 3, K_B = 4,
                   K_BEQ = 5, K_BNE = 6, K_LOAD = 7, K_STORE = 8, K_BAD = 9;

    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'b100000:                     return K_R;
            6'b111000, 6'b111001, 6'b110000: return K_ADD;
            6'b110010:                     return K_NANDI;
            6'b110011:                     return K_ORI;
            6'b111111:                     return K_B;
            6'b000000:                     return K_BEQ;
            6'b000001:                     return K_BNE;
            6'b000011, 6'b001111:          return K_LOAD;
            6'b000111, 6'b011111:          return K_STORE;
            default:                       return K_BAD;
        endcase
    endfunction

    // Cycles to observe for one instruction (trapped ones are watched a while)
    function automatic int inst_len(input int cls);
        case (cls)
            K_B, K_BEQ, K_BNE: return 3;
            K_LOAD:            return 5;
            K_BAD:             return c_TRAP ? 8 : 3;
            default:           return 4;
        endcase
    endfunction

    // Expected control word in cycle c (0 = FETCH) of an instruction
    function automatic logic [11:0] model(input int cls, input logic [3:0] fn,
                                          input logic z, input int c);
        logic       e, pcs, rsw, bsel, rwe, asel, mwe, ill;
        logic [3:0] f;
        {e, pcs, rsw, bsel, rwe, asel, mwe, ill} = '0;
        f = 4'b0000;
        if (c >= 2) begin
            if (cls == K_BAD) begin
                if (c_TRAP) ill = 1'b1;
                else if (c == 2) e = 1'b1;
            end else begin
                case (cls)
                    K_R:           f = fn;
                    K_ADD, K_LOAD: asel = 1'b1;
                    K_STORE:       begin asel = 1'b1; bsel = 1'b1; end
                    K_NANDI:       begin asel = 1'b1; f = 4'b0101; end
                    K_ORI:         begin asel = 1'b1; f = 4'b0011; end
                    K_BEQ, K_BNE:  begin bsel = 1'b1; f = 4'b0001; end
                    default:       ;
                endcase
                if (c == 2 && (cls == K_B || cls == K_BEQ || cls == K_BNE)) begin
                    e   = 1'b1;
                    pcs = (cls == K_B) || (cls == K_BEQ && z) || (cls == K_BNE && !z);
                end
                if (c == 3 && cls == K_STORE) begin
                    mwe = 1'b1; e = 1'b1;
                end
                if (c == 3 && (cls == K_R || cls == K_ADD || cls == K_NANDI || cls == K_ORI)) begin
                    rwe = 1'b1; e = 1'b1;
                end
                if (c == 4 && cls == K_LOAD) begin
                    rwe = 1'b1; rsw = 1'b1; e = 1'b1;
                end
            end
        end
        return {e, pcs, rsw, bsel, rwe, asel, mwe, f, ill};
    endfunction

    // Runs one instruction starting at a negedge in FETCH; ends at the negedge
    // that begins the next FETCH. rst_at >= 0 asserts reset for two cycles
    // from that cycle on; zforce < 0 randomizes zero every cycle.
    task automatic run_instr(input logic [5:0] op, input logic [3:0] fn,
                             input int rst_at, input int zforce);
        int cls, n;
        cls   = op_class(op);
        n     = inst_len(cls);
        instr = {op, 22'($urandom), fn};
        for (int c = 0; c < n; c++) begin
            zero = (zforce < 0) ? 1'($urandom_range(0, 1)) : 1'(zforce);
            if (c == rst_at) begin
                reset = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    #1 check($sformatf("reset op=%b cyc=%0d", op, c + k), 32'(w_dut_vec), 32'h0);
                    @(negedge clk);
                end
                reset = 1'b0;
                return;
            end
            #1 check($sformatf("op=%b fn=%h cyc=%0d z=%b", op, fn, c, zero),
                     32'(w_dut_vec), 32'(model(cls, fn, zero, c)));
            @(negedge clk);
        end
        if (c_TRAP && cls == K_BAD) begin
            reset = 1'b1;
            #1 check("halt_reset", 32'(w_dut_vec), 32'h0);
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    logic [5:0] legal_ops [13] = '{6'b100000, 6'b111000, 6'b111001, 6'b110000,
                                   6'b110010, 6'b110011, 6'b111111, 6'b000000,
                                   6'b000001, 6'b000011, 6'b000111, 6'b001111,
                                   6'b011111};

    initial begin
        logic [5:0] op;
        int         n;
        reset = 1'b1;
        zero  = 1'b0;
        instr = '0;
        repeat (2) begin
            @(negedge clk);
            #1 check("reset_init", 32'(w_dut_vec), 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Reset held two cycles while in WB of an ALU op, then a clean run
        run_instr(6'b100000, 4'b0000, 3, -1);
        run_instr(6'b100000, 4'b0000, -1, -1);  // R-type add
        run_instr(6'b001111, 4'b0000, -1, -1);  // lw
        run_instr(6'b011111, 4'b0000, -1, -1);  // sw
        run_instr(6'b000000, 4'b0000, -1, 1);   // beq, zero=1
        run_instr(6'b000001, 4'b0000, -1, 1);   // bne, zero=1
        run_instr(6'b000001, 4'b0000, -1, 0);   // bne, zero=0
        run_instr(6'b111111, 4'b0000, -1, 0);   // b
        run_instr(6'b101010, 4'b0000, -1, -1);  // undefined opcode
        run_instr(6'b100000, 4'b0101, -1, -1);  // R-type with nand func

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 6'($urandom); while (op_class(op) != K_BAD);
            end else begin
                op = legal_ops[$urandom_range(0, 12)];
            end
            n = inst_len(op_class(op));
            run_instr(op, 4'($urandom),
                      ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, n - 1)) : -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
